rsa_mont_prep: RTL and testbench

RSA_MONT_PREP -- requirements
Module: rsa_mont_prep

---
 rtl/rsa_mont_prep.sv | 96 +++++++++
 tb/tb_rsa_mont_prep.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rsa_mont_prep.sv
// rtl/rsa_mont_prep.sv - Montgomery pre-computation of R^2 mod N (R = 2^MOD_WIDTH) by repeated modular doubling
module rsa_mont_prep #(
    parameter int MOD_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [MOD_WIDTH-1:0] i_msg,
    input  logic [MOD_WIDTH-1:0] i_key,
    input  logic [MOD_WIDTH-1:0] i_modulus,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [MOD_WIDTH-1:0] o_base,
    output logic [MOD_WIDTH-1:0] o_msg,
    output logic [MOD_WIDTH-1:0] o_key,
    output logic [MOD_WIDTH-1:0] o_modulus
);
    localparam int ITERS = 2 * MOD_WIDTH;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [MOD_WIDTH:0]   r_q;
    logic [MOD_WIDTH:0]   t;
    logic [MOD_WIDTH:0]   r_next;
    logic [MOD_WIDTH-1:0] msg_q, key_q, mod_q;
    logic                 n_small;
    logic                 last_iter;

    // r < N < 2^MOD_WIDTH, so doubling never overflows the extra bit
    always_comb begin
        t         = r_q << 1;
        r_next    = (t >= {1'b0, mod_q}) ? (t - {1'b0, mod_q}) : t;
        n_small   = (mod_q[MOD_WIDTH-1:1] == '0);
        last_iter = (cnt_q == CW'(ITERS - 1));
    end

    always_comb begin
        state_d = state_q;
        i_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) state_d = CALC;
            end
            CALC: begin
                if (last_iter) state_d = OUT;
            end
            OUT: begin
                o_valid = 1'b1;
                if (o_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            msg_q   <= '0;
            key_q   <= '0;
            mod_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        msg_q <= i_msg;
                        key_q <= i_key;
                        mod_q <= i_modulus;
                        cnt_q <= '0;
                        // N of 0 or 1 has residue 0; start from 0 and never update
                        r_q   <= (i_modulus[MOD_WIDTH-1:1] != '0) ? (MOD_WIDTH+1)'(1) : '0;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (!n_small) r_q <= r_next;
                end
                default: ;
            endcase
        end
    end

    assign o_base    = r_q[MOD_WIDTH-1:0];
    assign o_msg     = msg_q;
    assign o_key     = key_q;
    assign o_modulus = mod_q;

endmodule

// File: tb/tb_rsa_mont_prep.sv
// tb/tb_rsa_mont_prep.sv - randomized self-checking bench for rsa_mont_prep (8-bit and 256-bit instances)
module tb_rsa_mont_prep;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic       a_iv, a_ir, a_ov, a_or;
    logic [7:0] a_msg, a_key, a_mod, a_ob, a_om, a_ok, a_on;
    logic         b_iv, b_ir, b_ov, b_or;
    logic [255:0] b_msg, b_key, b_mod, b_ob, b_om, b_ok, b_on;

    int errors = 0;
    int checks = 0;

    rsa_mont_prep #(.MOD_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .i_valid(a_iv), .i_ready(a_ir),
        .i_msg(a_msg), .i_key(a_key), .i_modulus(a_mod),
        .o_valid(a_ov), .o_ready(a_or), .o_base(a_ob),
        .o_msg(a_om), .o_key(a_ok), .o_modulus(a_on)
    );

    rsa_mont_prep #(.MOD_WIDTH(256)) dut_b (
        .clk(clk), .rst(rst), .i_valid(b_iv), .i_ready(b_ir),
        .i_msg(b_msg), .i_key(b_key), .i_modulus(b_mod),
        .o_valid(b_ov), .o_ready(b_or), .o_base(b_ob),
        .o_msg(b_om), .o_key(b_ok), .o_modulus(b_on)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref8(input logic [7:0] n);
        if (n < 8'd2) return 8'd0;
        return 8'(65536 % int'(n));
    endfunction

    function automatic logic [255:0] ref256(input logic [255:0] n);
        logic [512:0] p;
        if (n < 256'd2) return '0;
        p = '0;
        p[512] = 1'b1;
        p = p % {257'b0, n};
        return p[255:0];
    endfunction

    // Called at a negedge; returns #1 after the handshake edge with i_valid dropped
    task automatic send8(input logic [7:0] n, input logic [7:0] m, input logic [7:0] k);
        int g = 0;
        a_mod = n; a_msg = m; a_key = k; a_iv = 1'b1;
        while (!a_ir && g < 100) begin @(negedge clk); g++; end
        check("a_accept_timeout", 256'(g < 100), 256'd1);
        @(posedge clk); #1;
        a_iv = 1'b0; a_mod = 8'($urandom); a_msg = 8'($urandom); a_key = 8'($urandom);
    endtask

    task automatic recv8(input logic [7:0] n, input logic [7:0] m, input logic [7:0] k, input int stall);
        int lat = 0;
        logic [7:0] e = ref8(n);
        do begin @(negedge clk); lat++; end while (!a_ov && lat < 100);
        check("a_latency", 256'(lat), 256'd17);
        check("a_base", 256'(a_ob), 256'(e));
        check("a_msg", 256'(a_om), 256'(m));
        check("a_key", 256'(a_ok), 256'(k));
        check("a_mod", 256'(a_on), 256'(n));
        for (int s = 0; s < stall; s++) begin
            a_iv = 1'b1; a_mod = 8'($urandom); a_msg = 8'($urandom); a_key = 8'($urandom);
            @(negedge clk);
            check("a_hold_valid", 256'(a_ov), 256'd1);
            check("a_hold_iready", 256'(a_ir), 256'd0);
            check("a_hold_base", 256'({a_ob, a_om, a_ok, a_on}), 256'({e, m, k, n}));
        end
        a_iv = 1'b0;
        a_or = 1'b1;
        @(posedge clk); #1;
        a_or = 1'b0;
        @(negedge clk);
        check("a_post_ovalid", 256'(a_ov), 256'd0);
        check("a_post_iready", 256'(a_ir), 256'd1);
    endtask

    task automatic run256(input logic [255:0] n);
        int g = 0;
        int lat = 0;
        logic [255:0] m = {8{$urandom}};
        logic [255:0] k = {8{$urandom}};
        b_mod = n; b_msg = m; b_key = k; b_iv = 1'b1;
        while (!b_ir && g < 100) begin @(negedge clk); g++; end
        check("b_accept_timeout", 256'(g < 100), 256'd1);
        @(posedge clk); #1;
        b_iv = 1'b0; b_mod = '0;
        do begin @(negedge clk); lat++; end while (!b_ov && lat < 2000);
        check("b_latency", 256'(lat), 256'd513);
        check("b_base", b_ob, ref256(n));
        check("b_msg", b_om, m);
        check("b_key", b_ok, k);
        check("b_mod", b_on, n);
        b_or = 1'b1;
        @(posedge clk); #1;
        b_or = 1'b0;
        @(negedge clk);
        check("b_post_iready", 256'(b_ir), 256'd1);
    endtask

    initial begin
        logic [7:0] n, m, k;
        logic [255:0] nb;
        int seen;
        rst = 1'b1;
        a_iv = 0; a_or = 0; a_msg = 0; a_key = 0; a_mod = 0;
        b_iv = 0; b_or = 0; b_msg = '0; b_key = '0; b_mod = '0;
        repeat (3) @(negedge clk);
        check("rst_a_iready", 256'(a_ir), 256'd1);
        check("rst_a_ovalid", 256'(a_ov), 256'd0);
        check("rst_a_data", 256'({a_ob, a_om, a_ok, a_on}), 256'd0);
        check("rst_b_state", 256'({b_ir, b_ov}), 256'b10);
        rst = 1'b0;
        @(negedge clk);

        send8(8'd13, 8'h05, 8'h0B); recv8(8'd13, 8'h05, 8'h0B, 0);
        send8(8'd255, 8'h11, 8'h22); recv8(8'd255, 8'h11, 8'h22, 0);
        send8(8'h80, 8'h33, 8'h44); recv8(8'h80, 8'h33, 8'h44, 0);
        send8(8'd1, 8'h55, 8'h66); recv8(8'd1, 8'h55, 8'h66, 0);
        send8(8'd0, 8'h77, 8'h88); recv8(8'd0, 8'h77, 8'h88, 0);
        send8(8'd13, 8'hA1, 8'hB2); recv8(8'd13, 8'hA1, 8'hB2, 10);

        // reset in the middle of a computation discards the request
        send8(8'd13, 8'h01, 8'h02);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_iready", 256'(a_ir), 256'd1);
        check("midrst_ovalid", 256'(a_ov), 256'd0);
        check("midrst_data", 256'({a_ob, a_on}), 256'd0);
        seen = 0;
        repeat (30) begin @(negedge clk); if (a_ov) seen++; end
        check("midrst_no_output", 256'(seen), 256'd0);
        send8(8'd13, 8'h09, 8'h0A); recv8(8'd13, 8'h09, 8'h0A, 0);

        // back-to-back with i_valid held across the output handshake
        send8(8'd13, 8'h21, 8'h31);
        a_iv = 1'b1; a_mod = 8'd255; a_msg = 8'h41; a_key = 8'h51;
        seen = 0;
        do begin @(negedge clk); seen++; end while (!a_ov && seen < 100);
        check("b2b_lat1", 256'(seen), 256'd17);
        check("b2b_base1", 256'(a_ob), 256'd3);
        check("b2b_iready_busy", 256'(a_ir), 256'd0);
        a_or = 1'b1;
        @(posedge clk); #1;
        a_or = 1'b0;
        @(negedge clk);
        check("b2b_iready_next", 256'(a_ir), 256'd1);
        @(posedge clk); #1;
        a_iv = 1'b0;
        recv8(8'd255, 8'h41, 8'h51, 0);

        for (int i = 0; i < 12; i++) begin
            n = 8'($urandom); m = 8'($urandom); k = 8'($urandom);
            send8(n, m, k);
            recv8(n, m, k, int'($urandom_range(0, 3)));
        end

        nb = '0; nb[255] = 1'b1; nb[0] = 1'b1;
        run256(nb);
        run256('1);
        nb = {8{$urandom}}; nb[255] = 1'b1;
        run256(nb);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
